bar_height_writer: RTL



---
 rtl/bar_height_writer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bar_height_writer.sv
// rtl/bar_height_writer.sv - peak-magnitude bar height producer for the VGA bar-graph RAM
//
// Purpose:
//   Reads signed audio samples from the read side of the sample FIFO. For each
//   window of SAMPLES_PER_BAR samples it keeps the peak magnitude, then writes
//   min(peak >> SHIFT, 63) to RAM address bar_idx. After NUM_BARS bars it holds
//   data_back high for HOLDOFF_CYCLES cycles so the display side copies the frame.
//
// Ports:
//   clk           in   system clock (FIFO read clock and RAM clock)
//   reset_n       in   synchronous active-low reset
//   enable        in   gates new FIFO reads; captures already in flight still land
//   fifo_q        in   FIFO read data; sample is signed fifo_q[31:16]
//   fifo_rdempty  in   FIFO empty flag
//   fifo_rdreq    out  FIFO read request (normal mode: data valid next cycle)
//   ram_data      out  bar height to write
//   ram_wraddress out  bar RAM write address
//   ram_wren      out  bar RAM write enable (one cycle per bar)
//   data_back     out  frame-complete flag; its rising edge starts the copy
//   busy          out  high while filling or writing a bar

module bar_height_writer #(
  parameter int NUM_BARS        = 20,
  parameter int SAMPLES_PER_BAR = 64,
  parameter int SHIFT           = 9,
  parameter int HOLDOFF_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] fifo_q,
  input  logic        fifo_rdempty,
  output logic        fifo_rdreq,
  output logic [5:0]  ram_data,
  output logic [5:0]  ram_wraddress,
  output logic        ram_wren,
  output logic        data_back,
  output logic        busy
);

  localparam int CW = $clog2(SAMPLES_PER_BAR + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_WRITE   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      bar_idx_q, bar_idx_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   captured_q, captured_d;
  logic [16:0]     peak_q, peak_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            valid_q, valid_d;
  logic            ram_wren_q, ram_wren_d;
  logic [5:0]      ram_data_q, ram_data_d;
  logic [5:0]      ram_wraddress_q, ram_wraddress_d;
  logic            data_back_q, data_back_d;
  logic            busy_q, busy_d;

  logic            rd_req;
  logic [16:0]     sample_ext;
  logic [16:0]     mag;
  logic [16:0]     peak_max;
  logic [16:0]     shifted;
  logic [5:0]      height;
  logic            unused_low;

  assign unused_low = ^fifo_q[15:0];

  // 17-bit magnitude so that -32768 maps to +32768 without wrapping.
  assign sample_ext = {fifo_q[31], fifo_q[31:16]};
  assign mag        = fifo_q[31] ? (17'd0 - sample_ext) : sample_ext;
  assign peak_max   = (valid_q && (mag > peak_q)) ? mag : peak_q;
  assign shifted    = peak_max >> SHIFT;
  assign height     = (shifted > 17'd63) ? 6'd63 : shifted[5:0];

  // Gated by reset_n so nothing is popped from the FIFO while held in reset.
  assign rd_req = reset_n & enable & ~fifo_rdempty & (state_q == S_FILL) &
                  (issued_q < CW'(SAMPLES_PER_BAR));

  always_comb begin
    state_d         = state_q;
    bar_idx_d       = bar_idx_q;
    issued_d        = issued_q;
    captured_d      = captured_q;
    peak_d          = peak_q;
    hold_d          = hold_q;
    valid_d         = rd_req;
    ram_wren_d      = 1'b0;
    ram_data_d      = ram_data_q;
    ram_wraddress_d = ram_wraddress_q;
    data_back_d     = data_back_q;

    case (state_q)
      S_FILL: begin
        if (rd_req) begin
          issued_d = issued_q + CW'(1);
        end
        // Data for the previous cycle's request is on fifo_q now.
        if (valid_q) begin
          peak_d     = peak_max;
          captured_d = captured_q + CW'(1);
          if (captured_q == CW'(SAMPLES_PER_BAR - 1)) begin
            state_d         = S_WRITE;
            ram_wren_d      = 1'b1;
            ram_wraddress_d = bar_idx_q;
            ram_data_d      = height;
          end
        end
      end

      S_WRITE: begin
        peak_d     = 17'd0;
        issued_d   = '0;
        captured_d = '0;
        if (bar_idx_q == 6'(NUM_BARS - 1)) begin
          bar_idx_d   = 6'd0;
          state_d     = S_HOLDOFF;
          data_back_d = 1'b1;
          hold_d      = '0;
        end else begin
          bar_idx_d = bar_idx_q + 6'd1;
          state_d   = S_FILL;
        end
      end

      S_HOLDOFF: begin
        if (hold_q == HW'(HOLDOFF_CYCLES - 1)) begin
          data_back_d = 1'b0;
          state_d     = S_FILL;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase

    busy_d = (state_d != S_HOLDOFF);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_FILL;
      bar_idx_q       <= 6'd0;
      issued_q        <= '0;
      captured_q      <= '0;
      peak_q          <= 17'd0;
      hold_q          <= '0;
      valid_q         <= 1'b0;
      ram_wren_q      <= 1'b0;
      ram_data_q      <= 6'd0;
      ram_wraddress_q <= 6'd0;
      data_back_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bar_idx_q       <= bar_idx_d;
      issued_q        <= issued_d;
      captured_q      <= captured_d;
      peak_q          <= peak_d;
      hold_q          <= hold_d;
      valid_q         <= valid_d;
      ram_wren_q      <= ram_wren_d;
      ram_data_q      <= ram_data_d;
      ram_wraddress_q <= ram_wraddress_d;
      data_back_q     <= data_back_d;
      busy_q          <= busy_d;
    end
  end

  assign fifo_rdreq    = rd_req;
  assign ram_wren      = ram_wren_q;
  assign ram_data      = ram_data_q;
  assign ram_wraddress = ram_wraddress_q;
  assign data_back     = data_back_q;
  assign busy          = busy_q;

endmodule
